// File: rtl/mmio_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mmio_timer                                                   |
// | Description : Memory-mapped down-counting timer with reload, byte-enabled  |
// |               register writes, zero-latency reads and a sticky W1C         |
// |               interrupt status bit. Optional prescaler behind the macro    |
// |               MMIO_TIMER_PRESCALER_EN (PSC register at offset 0x10).       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          PSC_W     = 16
) (
  input  logic        clk,
  input  logic        rst,        // asynchronous, active-low
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  vldbyte_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        int_o
);

  localparam logic [2:0] c_off_ctrl   = 3'd0;
  localparam logic [2:0] c_off_load   = 3'd1;
  localparam logic [2:0] c_off_count  = 3'd2;
  localparam logic [2:0] c_off_status = 3'd3;
  localparam logic [2:0] c_off_psc    = 3'd4;

  // Byte-lane merge: keep old bytes where the enable is low.
  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  be);
    f_merge = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) f_merge[8*i +: 8] = new_v[8*i +: 8];
    end
  endfunction

  logic        r_en, r_ar, r_ie, r_pend;
  logic [31:0] r_load, r_count;
  logic [31:0] w_rdata;
  logic [2:0]  w_off;
  logic        w_hit, w_wr, w_rd, w_any_be;
  logic        w_wr_ctrl, w_wr_load, w_wr_count, w_w1c;
  logic        w_tick, w_expire;
  logic        w_unused;

  assign w_hit    = (addr_i[31:5] == BASE_ADDR[31:5]);
  assign w_off    = addr_i[4:2];
  assign w_wr     = ce_i & we_i & w_hit;
  assign w_rd     = ce_i & ~we_i & w_hit;
  assign w_any_be = |vldbyte_i;

  // CTRL lives entirely in byte 0, so only that lane can change it.
  assign w_wr_ctrl  = w_wr && (w_off == c_off_ctrl) && vldbyte_i[0];
  assign w_wr_load  = w_wr && (w_off == c_off_load) && w_any_be;
  assign w_wr_count = w_wr && (w_off == c_off_count) && w_any_be;
  assign w_w1c      = w_wr && (w_off == c_off_status) && vldbyte_i[0] && data_i[0];

  assign w_expire = w_tick && (r_count == 32'd0);

`ifdef MMIO_TIMER_PRESCALER_EN
  logic [PSC_W-1:0] r_psc, r_psc_cnt;
  logic [31:0]      w_psc_merged;
  logic             w_wr_psc, w_en_rise;

  assign w_wr_psc     = w_wr && (w_off == c_off_psc) && w_any_be;
  assign w_en_rise    = w_wr_ctrl && data_i[0] && !r_en;
  assign w_psc_merged = f_merge(32'(r_psc), data_i, vldbyte_i);
  assign w_tick       = r_en && (r_psc_cnt == r_psc);
  assign w_unused     = ^{addr_i[1:0], w_psc_merged[31:PSC_W]};

  // Prescaler reload value, written through byte lanes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_psc <= '0;
    else if (w_wr_psc) r_psc <= w_psc_merged[PSC_W-1:0];
  end

  // Prescaler phase: restarts on PSC write or on enabling the timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        r_psc_cnt <= '0;
    else if (w_wr_psc || w_en_rise)  r_psc_cnt <= '0;
    else if (r_en)                   r_psc_cnt <= (r_psc_cnt == r_psc) ? '0 : r_psc_cnt + PSC_W'(1);
  end
`else
  assign w_tick   = r_en;
  assign w_unused = ^{addr_i[1:0], (PSC_W > 0)};
`endif

  // CTRL: bus write wins; a one-shot expiry otherwise clears EN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {r_ie, r_ar, r_en} <= 3'b000;
    end else if (w_wr_ctrl) begin
      {r_ie, r_ar, r_en} <= data_i[2:0];
    end else if (w_expire && !r_ar) begin
      r_en <= 1'b0;
    end
  end

  // LOAD: plain byte-enabled register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_load <= '0;
    else if (w_wr_load) r_load <= f_merge(r_load, data_i, vldbyte_i);
  end

  // COUNT: a bus write suppresses the decrement/reload of that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (w_wr_count) begin
      r_count <= f_merge(r_count, data_i, vldbyte_i);
    end else if (w_tick) begin
      if (r_count != 32'd0) r_count <= r_count - 32'd1;
      else if (r_ar)        r_count <= r_load;
    end
  end

  // PEND: expiry has priority over W1C so a coincident event is not lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_pend <= 1'b0;
    else if (w_expire) r_pend <= 1'b1;
    else if (w_w1c)    r_pend <= 1'b0;
  end

  // Zero-latency read mux; anything unselected reads as zero.
  always_comb begin
    w_rdata = 32'h0;
    if (w_rd) begin
      case (w_off)
        c_off_ctrl:   w_rdata = {29'b0, r_ie, r_ar, r_en};
        c_off_load:   w_rdata = r_load;
        c_off_count:  w_rdata = r_count;
        c_off_status: w_rdata = {31'b0, r_pend};
`ifdef MMIO_TIMER_PRESCALER_EN
        c_off_psc:    w_rdata = 32'(r_psc);
`endif
        default:      w_rdata = 32'h0;
      endcase
    end
  end

  assign data_o = w_rdata;
  assign int_o  = r_pend & r_ie;

endmodule
`default_nettype wire

// File: tb/tb_mmio_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mmio_timer                                                |
// | Description : Directed self-checking bench for mmio_timer. Inputs change   |
// |               in the clock low phase; outputs are sampled there as well.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_mmio_timer;

  localparam logic [31:0] c_base   = 32'h1000_0000;
  localparam logic [31:0] c_ctrl   = c_base + 32'h00;
  localparam logic [31:0] c_load   = c_base + 32'h04;
  localparam logic [31:0] c_count  = c_base + 32'h08;
  localparam logic [31:0] c_status = c_base + 32'h0C;
  localparam logic [31:0] c_psc    = c_base + 32'h10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [3:0]  vldbyte_i = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic        int_o;

  int errors = 0;
  int checks = 0;

  mmio_timer #(.BASE_ADDR(c_base), .PSC_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce_i      (ce_i),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .vldbyte_i (vldbyte_i),
    .data_i    (data_i),
    .data_o    (data_o),
    .int_o     (int_o)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One bus write, consuming exactly one rising edge; returns in the low phase.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    ce_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = d; vldbyte_i = be;
    @(posedge clk);
    @(negedge clk);
    ce_i = 1'b0; we_i = 1'b0; vldbyte_i = 4'b0000;
  endtask

  // Combinational read, no clock edge consumed.
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    ce_i = 1'b1; we_i = 1'b0; addr_i = a;
    #1;
    chk(tag, data_o, exp);
    ce_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_int", {31'b0, int_o}, 32'h0);
    rd("rst_ctrl", c_ctrl, 32'h0);
    rd("rst_count", c_count, 32'h0);
    rst = 1'b1;
    step();

    // Reset in the middle of counting: COUNT=5, EN=1, PEND=1, IE=1
    wr(c_load, 32'd5, 4'hF);
    wr(c_ctrl, 32'h7, 4'hF);
    step();                               // first tick: expiry from 0, reload 5
    chk("pre_rst_int", {31'b0, int_o}, 32'h1);
    rd("pre_rst_count", c_count, 32'd5);
    rd("pre_rst_status", c_status, 32'h1);
    #1 rst = 1'b0;
    #1 chk("async_rst_int", {31'b0, int_o}, 32'h0);
    rd("async_rst_ctrl", c_ctrl, 32'h0);
    rd("async_rst_count", c_count, 32'h0);
    rd("async_rst_load", c_load, 32'h0);
    rd("async_rst_status", c_status, 32'h0);
    rst = 1'b1;
    step();

    // Byte enables, out-of-window and empty-enable writes
    wr(c_load, 32'hAABB_CCDD, 4'b0101);
    rd("be_load", c_load, 32'h00BB_00DD);
    wr(32'h2000_0004, 32'h1234_5678, 4'hF);
    rd("miss_wr_load", c_load, 32'h00BB_00DD);
    rd("miss_rd", 32'h2000_0004, 32'h0);
    wr(c_load, 32'hFFFF_FFFF, 4'b0000);
    rd("be0_load", c_load, 32'h00BB_00DD);
    rd("unmapped_14", c_base + 32'h14, 32'h0);

    // One-shot: LOAD=COUNT=3, CTRL=IE|EN
    wr(c_load, 32'd3, 4'hF);
    wr(c_count, 32'd3, 4'hF);
    wr(c_ctrl, 32'h5, 4'hF);              // EN rises, no tick this edge
    rd("os_no_tick", c_count, 32'd3);
    step();
    rd("os_t1", c_count, 32'd2);
    step();
    step();
    rd("os_t3", c_count, 32'd0);
    rd("os_t3_status", c_status, 32'h0);
    step();                               // 4th tick: expiry
    chk("os_int", {31'b0, int_o}, 32'h1);
    rd("os_status", c_status, 32'h1);
    rd("os_ctrl", c_ctrl, 32'h4);
    rd("os_count", c_count, 32'd0);
    step();
    rd("os_frozen", c_count, 32'd0);
    wr(c_status, 32'h1, 4'hF);
    rd("os_w1c", c_status, 32'h0);
    chk("os_w1c_int", {31'b0, int_o}, 32'h0);

    // Auto-reload: COUNT=0, LOAD=2, CTRL=IE|AR|EN; expiries at ticks 1,4,7
    wr(c_load, 32'd2, 4'hF);
    wr(c_ctrl, 32'h7, 4'hF);
    step();                               // tick 1
    rd("ar_t1_status", c_status, 32'h1);
    rd("ar_t1_count", c_count, 32'd2);
    wr(c_status, 32'h1, 4'hF);            // tick 2 plus clear
    rd("ar_t2_status", c_status, 32'h0);
    rd("ar_t2_count", c_count, 32'd1);
    step();                               // tick 3
    rd("ar_t3_status", c_status, 32'h0);
    wr(c_status, 32'h1, 4'hF);            // tick 4 expiry with coincident W1C
    rd("ar_t4_status", c_status, 32'h1);
    rd("ar_t4_count", c_count, 32'd2);
    wr(c_status, 32'h1, 4'hF);            // tick 5, clear
    step();                               // tick 6
    rd("ar_t6_status", c_status, 32'h0);
    step();                               // tick 7 expiry
    rd("ar_t7_status", c_status, 32'h1);
    chk("ar_t7_int", {31'b0, int_o}, 32'h1);

    // Collision: write COUNT=9 on the 1->0 tick
    wr(c_ctrl, 32'h0, 4'hF);
    wr(c_status, 32'h1, 4'hF);
    wr(c_count, 32'd2, 4'hF);
    wr(c_ctrl, 32'h1, 4'hF);
    step();
    rd("col_pre", c_count, 32'd1);
    wr(c_count, 32'd9, 4'hF);
    rd("col_kept", c_count, 32'd9);
    step();
    rd("col_dec8", c_count, 32'd8);
    step();
    rd("col_dec7", c_count, 32'd7);
    rd("col_status", c_status, 32'h0);

    // Disabling EN in the same cycle as a one-shot expiry
    wr(c_ctrl, 32'h0, 4'hF);
    wr(c_count, 32'd0, 4'hF);
    wr(c_ctrl, 32'h1, 4'hF);
    wr(c_ctrl, 32'h0, 4'hF);              // expiry tick coincides with EN=0 write
    rd("dis_status", c_status, 32'h1);
    rd("dis_ctrl", c_ctrl, 32'h0);
    wr(c_status, 32'h1, 4'hF);

`ifdef MMIO_TIMER_PRESCALER_EN
    // Prescaler: PSC=3, COUNT=1 -> COUNT 0 after 4 cycles, PEND after 8
    wr(c_psc, 32'hFFFF_0003, 4'hF);
    rd("psc_read", c_psc, 32'h0000_0003);
    wr(c_count, 32'd1, 4'hF);
    wr(c_ctrl, 32'h1, 4'hF);
    repeat (3) step();
    rd("psc_c3", c_count, 32'd1);
    step();
    rd("psc_c4", c_count, 32'd0);
    repeat (3) step();
    rd("psc_c7", c_status, 32'h0);
    step();
    rd("psc_c8", c_status, 32'h1);
`else
    // Offset 0x10 is unmapped without the prescaler
    wr(c_psc, 32'h0000_0003, 4'hF);
    rd("psc_off", c_psc, 32'h0);
    wr(c_count, 32'd1, 4'hF);
    wr(c_ctrl, 32'h1, 4'hF);
    step();
    rd("nopsc_c1", c_count, 32'd0);
    step();
    rd("nopsc_c2", c_status, 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
